// File: rtl/slip_clock_phase_gen.sv
// slip_clock_phase_gen: divides MasterClock into clkOut with edge strobes,
// an aligned active-low preset release and a stop/ack park handshake.
//
// Ports:
//   MasterClock  in   only clock, all state on its rising edge
//   resetL       in   asynchronous active-low reset
//   stopReq      in   level request to park clkOut low
//   stopAck      out  high while clkOut is parked
//   clkOut       out  divided clock, DIV_HALF cycles per half-period
//   riseStb      out  first cycle with clkOut==1
//   fallStb      out  first cycle with clkOut==0 after a fall
//   presetL      out  active-low preset for downstream storage cells
//   phaseCount   out  cycles elapsed in the current phase
module slip_clock_phase_gen #(
    parameter int DIV_HALF    = 2,
    parameter int CNT_W       = 4,
    parameter int PRESET_HOLD = 8
) (
    input  logic             MasterClock,
    input  logic             resetL,
    input  logic             stopReq,
    output logic             stopAck,
    output logic             clkOut,
    output logic             riseStb,
    output logic             fallStb,
    output logic             presetL,
    output logic [CNT_W-1:0] phaseCount
);
    typedef enum logic [1:0] {RUN_LOW, RUN_HIGH, STOPPED} state_t;
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DIV_HALF - 1);
    localparam logic [CNT_W-1:0] LP_HOLD = CNT_W'(PRESET_HOLD);
    state_t           r_state, w_state_nxt;
    logic             r_run;
    logic [CNT_W-1:0] r_hold, w_hold_nxt, w_phase_nxt;
    logic             w_last, w_clk_nxt, w_rise_nxt, w_fall_nxt, w_ack_nxt, w_preset_nxt;
    assign w_last = phaseCount == LP_LAST;
    // r_run is clear only until the first edge after reset; that edge is
    // cycle 0, the first low-phase cycle, so nothing but r_run advances on it.
    assign w_hold_nxt = (r_run && r_hold != LP_HOLD) ? r_hold + 1'b1 : r_hold;
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = phaseCount + 1'b1;
        w_clk_nxt    = clkOut;
        w_rise_nxt   = 1'b0;
        w_fall_nxt   = 1'b0;
        w_ack_nxt    = stopAck;
        w_preset_nxt = presetL;
        if (!r_run) begin
            w_phase_nxt = '0;
        end else begin
            case (r_state)
                RUN_LOW: begin
                    if (w_last) begin
                        w_phase_nxt = '0;
                        // a stop is only taken after a full low phase, so no runt low
                        if (presetL && stopReq) begin
                            w_state_nxt = STOPPED;
                            w_ack_nxt   = 1'b1;
                        end else begin
                            w_state_nxt = RUN_HIGH;
                            w_clk_nxt   = 1'b1;
                            w_rise_nxt  = 1'b1;
                        end
                    end
                end
                RUN_HIGH: begin
                    if (w_last) begin
                        w_phase_nxt = '0;
                        w_state_nxt = RUN_LOW;
                        w_clk_nxt   = 1'b0;
                        w_fall_nxt  = 1'b1;
                        // release preset only on a fall, half a period from any rise
                        if (w_hold_nxt == LP_HOLD) w_preset_nxt = 1'b1;
                    end
                end
                STOPPED: begin
                    w_phase_nxt = '0;
                    if (!stopReq) begin
                        w_state_nxt = RUN_HIGH;
                        w_clk_nxt   = 1'b1;
                        w_rise_nxt  = 1'b1;
                        w_ack_nxt   = 1'b0;
                    end
                end
                default: begin
                    w_state_nxt = RUN_LOW;
                    w_phase_nxt = '0;
                    w_clk_nxt   = 1'b0;
                    w_ack_nxt   = 1'b0;
                end
            endcase
        end
    end
    always_ff @(posedge MasterClock or negedge resetL) begin
        if (!resetL) begin
            r_state    <= RUN_LOW;
            r_run      <= 1'b0;
            r_hold     <= '0;
            phaseCount <= '0;
            clkOut     <= 1'b0;
            riseStb    <= 1'b0;
            fallStb    <= 1'b0;
            stopAck    <= 1'b0;
            presetL    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_run      <= 1'b1;
            r_hold     <= w_hold_nxt;
            phaseCount <= w_phase_nxt;
            clkOut     <= w_clk_nxt;
            riseStb    <= w_rise_nxt;
            fallStb    <= w_fall_nxt;
            stopAck    <= w_ack_nxt;
            presetL    <= w_preset_nxt;
        end
    end
endmodule

// File: tb/tb_slip_clock_phase_gen.sv
// tb_slip_clock_phase_gen: checks two divider configurations against a cycle-index model
module tb_slip_clock_phase_gen;
    logic       clk = 1'b0;
    logic       resetL = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] o_clk, o_rise, o_fall, o_ack, o_pre;
    logic [3:0] ph0, ph1;
    int total = 0;
    int bad = 0;
    int n = -1;
    int m_clk[2], m_last[2], m_stop[2], m_pre[2], run[2], prev[2];
    always #5 clk = ~clk;
    slip_clock_phase_gen #(.DIV_HALF(2), .CNT_W(4), .PRESET_HOLD(8)) u_dut2 (
        .MasterClock(clk), .resetL(resetL), .stopReq(req[0]), .stopAck(o_ack[0]),
        .clkOut(o_clk[0]), .riseStb(o_rise[0]), .fallStb(o_fall[0]),
        .presetL(o_pre[0]), .phaseCount(ph0));
    slip_clock_phase_gen #(.DIV_HALF(1), .CNT_W(4), .PRESET_HOLD(4)) u_dut1 (
        .MasterClock(clk), .resetL(resetL), .stopReq(req[1]), .stopAck(o_ack[1]),
        .clkOut(o_clk[1]), .riseStb(o_rise[1]), .fallStb(o_fall[1]),
        .presetL(o_pre[1]), .phaseCount(ph1));
    function automatic int dh(input int k);
        return k ? 1 : 2;
    endfunction
    function automatic int ph(input int k);
        return k ? int'(ph1) : int'(ph0);
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0d want=%0d", tag, n, obs, exp);
        end
    endtask
    task automatic do_reset();
        resetL = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_clk", o_clk[k], 0);
            chk("rst_rise", o_rise[k], 0);
            chk("rst_fall", o_fall[k], 0);
            chk("rst_ack", o_ack[k], 0);
            chk("rst_pre", o_pre[k], 0);
            chk("rst_phase", ph(k), 0);
        end
        repeat (2) @(posedge clk);
        #1 resetL = 1'b1;
        n = -1;
        for (int k = 0; k < 2; k++) begin
            m_clk[k] = 0; m_last[k] = 0; m_stop[k] = 0; m_pre[k] = 0; run[k] = 0; prev[k] = 0;
        end
    endtask
    // Model: clkOut changes every DIV_HALF cycles from the last change; a low
    // phase ending with preset released and stop requested parks instead.
    task automatic step(input logic r0, input logic r1);
        logic [1:0] rq;
        rq = {r1, r0};
        req = rq;
        @(posedge clk);
        n++;
        for (int k = 0; k < 2; k++) begin
            if (n == 0) begin
            end else if (m_stop[k] != 0) begin
                if (!rq[k]) begin m_stop[k] = 0; m_clk[k] = 1; m_last[k] = n; end
            end else if (n == m_last[k] + dh(k)) begin
                m_last[k] = n;
                if (m_clk[k] != 0) begin
                    m_clk[k] = 0;
                    if (n >= (k ? 4 : 8)) m_pre[k] = 1;
                end else if (m_pre[k] != 0 && rq[k]) m_stop[k] = 1;
                else m_clk[k] = 1;
            end
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("m_clk", o_clk[k], m_clk[k]);
            chk("m_ack", o_ack[k], m_stop[k]);
            chk("m_pre", o_pre[k], m_pre[k]);
            chk("m_phase", ph(k), m_stop[k] != 0 ? 0 : n - m_last[k]);
            chk("m_rise", o_rise[k], m_stop[k] == 0 && m_clk[k] != 0 && m_last[k] == n);
            chk("m_fall", o_fall[k], n > 0 && m_stop[k] == 0 && m_clk[k] == 0 && m_last[k] == n);
            chk("ack_low", o_ack[k] & o_clk[k], 0);
            chk("strb_excl", o_rise[k] & o_fall[k], 0);
            if (n == 0) begin
                run[k] = 1;
            end else if (int'(o_clk[k]) == prev[k]) begin
                run[k]++;
            end else begin
                chk("min_phase", run[k] >= dh(k), 1);
                run[k] = 1;
            end
            prev[k] = int'(o_clk[k]);
        end
    endtask
    task automatic s1();
        for (int c = 0; c <= 12; c++) begin
            step(1'b0, 1'($urandom_range(0, 1)));
            chk("s1_clk", o_clk[0], n >= 2 && (n - 2) % 4 < 2);
            chk("s1_rise", o_rise[0], n == 2 || n == 6 || n == 10);
            chk("s1_pre", o_pre[0], n >= 8);
        end
    endtask
    task automatic s2(input int upto);
        for (int c = 0; c <= upto; c++) begin
            step(c >= 4 && c <= 20, 1'($urandom_range(0, 1)));
            chk("s2_clk", o_clk[0], n < 10 ? (n >= 2 && (n - 2) % 4 < 2) :
                                    n <= 20 ? 0 : (n - 21) % 4 < 2);
            chk("s2_ack", o_ack[0], n >= 10 && n <= 20);
            chk("s2_rise", o_rise[0], n == 2 || n == 6 || n == 21 || n == 25);
            chk("s2_fall", o_fall[0], n == 4 || n == 8 || n == 23);
        end
    endtask
    initial begin
        logic [1:0] r;
        #3;
        do_reset();
        s1();
        do_reset();
        s2(25);
        do_reset();
        s2(14);
        do_reset();
        r = 2'b00;
        for (int c = 0; c < 10000; c++) begin
            for (int k = 0; k < 2; k++) if ($urandom_range(0, 5) == 0) r[k] = ~r[k];
            step(r[0], r[1]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
